// File: rtl/kw_fifo_flex.sv
// kw_fifo_flex: single-clock flip-flop FIFO with arbitrary depth, runtime
// almost-empty/almost-full thresholds, fill-level output, synchronous clear
// and selectable registered or show-ahead read data.
module kw_fifo_flex #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int SHOW_AHEAD  = 0,
    parameter int ERR_MODE    = 1,
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push_req,
    input  logic                   pop_req,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    input  logic [LEVEL_WIDTH-1:0] ae_level,
    input  logic [LEVEL_WIDTH-1:0] af_level,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   empty,
    output logic                   almost_empty,
    output logic                   half_full,
    output logic                   almost_full,
    output logic                   full,
    output logic                   error
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [LEVEL_WIDTH-1:0] DEPTH_LVL = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] HALF_LVL  = LEVEL_WIDTH'((DEPTH + 1) / 2);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic                   push_ok;
    logic                   pop_ok;
    logic                   err_event;
    logic                   ptr_mismatch;
    logic [LEVEL_WIDTH-1:0] ptr_diff;
    int                     diff;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Status flags and request qualification from the registered level and live thresholds.
    always_comb begin
        empty        = (level == '0);
        full         = (level == DEPTH_LVL);
        almost_empty = (level <= ae_level);
        half_full    = (level >= HALF_LVL);
        // An offset at or beyond DEPTH pins the threshold at zero, so the flag is constant.
        almost_full  = (af_level >= DEPTH_LVL) ? 1'b1 : (level >= (DEPTH_LVL - af_level));

        // A pop frees a slot in the same cycle, so a full FIFO still takes a paired push.
        push_ok   = push_req && (!full || pop_req);
        pop_ok    = pop_req && !empty;
        err_event = (push_req && full && !pop_req) || (pop_req && empty);

        // Occupancy implied by the pointers; ambiguous only when full, where they coincide.
        diff = int'(wr_ptr) - int'(rd_ptr);
        if (diff < 0) begin
            diff = diff + DEPTH;
        end
        ptr_diff     = LEVEL_WIDTH'(diff);
        ptr_mismatch = (level != ptr_diff) && !(full && (wr_ptr == rd_ptr));
    end

    // Pointer, level and error state; clear returns everything to the reset values.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            error  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            error  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (ERR_MODE == 2) begin
                error <= err_event;
            end else begin
                error <= error || err_event || ((ERR_MODE == 0) && ptr_mismatch);
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; validity is tracked by level and the
        // pointers, and leaving it unreset keeps it plain flops without reset fan-out.
        if (push_ok && !clear) begin
            mem[wr_ptr] <= data_i;
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Head word is presented directly; meaningful only while non-empty.
            assign data_o = mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] data_q;

            // Read register loads the head word on each accepted pop and holds otherwise.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    data_q <= '0;
                end else if (clear) begin
                    data_q <= '0;
                end else if (pop_ok) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign data_o = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_kw_fifo_flex.sv
// Self-checking bench for kw_fifo_flex: registered-read instances at DEPTH=5
// (unlatched and consistency-checked error modes) plus a show-ahead instance
// at DEPTH=16 with latched error, each tracked by a queue scoreboard.
module tb_kw_fifo_flex;

    logic clock = 1'b0;
    logic reset_n;

    // Instances a and c share stimulus (DEPTH=5, registered read).
    logic       a_clear, a_push, a_pop;
    logic [7:0] a_din;
    logic [2:0] a_ae, a_af;
    logic [7:0] a_dout, c_dout;
    logic [2:0] a_level, c_level;
    logic       a_empty, a_aempty, a_half, a_afull, a_full, a_error;
    logic       c_empty, c_aempty, c_half, c_afull, c_full, c_error;

    // Instance b (DEPTH=16, show-ahead, latched error).
    logic       b_clear, b_push, b_pop;
    logic [7:0] b_din;
    logic [4:0] b_ae, b_af;
    logic [7:0] b_dout;
    logic [4:0] b_level;
    logic       b_empty, b_aempty, b_half, b_afull, b_full, b_error;

    int n_checks = 0;
    int n_errors = 0;

    // Reference models.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] da_exp;
    logic       ea_exp, ec_exp, eb_exp;

    kw_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .SHOW_AHEAD(0), .ERR_MODE(2)) u_a (
        .clock(clock), .reset_n(reset_n), .clear(a_clear), .push_req(a_push), .pop_req(a_pop),
        .data_i(a_din), .data_o(a_dout), .ae_level(a_ae), .af_level(a_af), .level(a_level),
        .empty(a_empty), .almost_empty(a_aempty), .half_full(a_half), .almost_full(a_afull),
        .full(a_full), .error(a_error)
    );

    kw_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .SHOW_AHEAD(0), .ERR_MODE(0)) u_c (
        .clock(clock), .reset_n(reset_n), .clear(a_clear), .push_req(a_push), .pop_req(a_pop),
        .data_i(a_din), .data_o(c_dout), .ae_level(a_ae), .af_level(a_af), .level(c_level),
        .empty(c_empty), .almost_empty(c_aempty), .half_full(c_half), .almost_full(c_afull),
        .full(c_full), .error(c_error)
    );

    kw_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .SHOW_AHEAD(1), .ERR_MODE(1)) u_b (
        .clock(clock), .reset_n(reset_n), .clear(b_clear), .push_req(b_push), .pop_req(b_pop),
        .data_i(b_din), .data_o(b_dout), .ae_level(b_ae), .af_level(b_af), .level(b_level),
        .empty(b_empty), .almost_empty(b_aempty), .half_full(b_half), .almost_full(b_afull),
        .full(b_full), .error(b_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_check(input string tag);
        int l;
        l = qa.size();
        check({tag, ".a.level"}, 32'(a_level), l);
        check({tag, ".a.empty"}, a_empty, l == 0);
        check({tag, ".a.almost_empty"}, a_aempty, l <= int'(a_ae));
        check({tag, ".a.half_full"}, a_half, l >= 3);
        check({tag, ".a.almost_full"}, a_afull, (int'(a_af) >= 5) ? 1'b1 : (l >= 5 - int'(a_af)));
        check({tag, ".a.full"}, a_full, l == 5);
        check({tag, ".a.data_o"}, a_dout, da_exp);
        check({tag, ".a.error"}, a_error, ea_exp);
        check({tag, ".c.level"}, 32'(c_level), l);
        check({tag, ".c.data_o"}, c_dout, da_exp);
        check({tag, ".c.error"}, c_error, ec_exp);
    endtask

    task automatic b_check(input string tag);
        int l;
        l = qb.size();
        check({tag, ".b.level"}, 32'(b_level), l);
        check({tag, ".b.empty"}, b_empty, l == 0);
        check({tag, ".b.almost_empty"}, b_aempty, l <= int'(b_ae));
        check({tag, ".b.half_full"}, b_half, l >= 8);
        check({tag, ".b.almost_full"}, b_afull, (int'(b_af) >= 16) ? 1'b1 : (l >= 16 - int'(b_af)));
        check({tag, ".b.full"}, b_full, l == 16);
        check({tag, ".b.error"}, b_error, eb_exp);
        if (l > 0) begin
            check({tag, ".b.data_o"}, b_dout, qb[0]);
        end
    endtask

    // One clock of stimulus on instances a/c, then model update and checks.
    task automatic a_step(input string tag, input logic push, input logic pop,
                          input logic clr, input logic [7:0] din);
        logic full_m, empty_m, push_acc, pop_acc, ev;
        a_push = push; a_pop = pop; a_clear = clr; a_din = din;
        full_m   = (qa.size() == 5);
        empty_m  = (qa.size() == 0);
        push_acc = push && (!full_m || pop);
        pop_acc  = pop && !empty_m;
        ev       = (push && full_m && !pop) || (pop && empty_m);
        @(posedge clock);
        #1;
        a_push = 1'b0; a_pop = 1'b0; a_clear = 1'b0;
        if (clr) begin
            qa.delete();
            da_exp = 8'h00;
            ea_exp = 1'b0;
            ec_exp = 1'b0;
        end else begin
            if (pop_acc) da_exp = qa.pop_front();
            if (push_acc) qa.push_back(din);
            ea_exp = ev;
            ec_exp = ec_exp | ev;
        end
        a_check(tag);
    endtask

    // One clock of stimulus on instance b, then model update and checks.
    task automatic b_step(input string tag, input logic push, input logic pop,
                          input logic clr, input logic [7:0] din);
        logic full_m, empty_m, push_acc, pop_acc, ev;
        logic [7:0] drop;
        b_push = push; b_pop = pop; b_clear = clr; b_din = din;
        full_m   = (qb.size() == 16);
        empty_m  = (qb.size() == 0);
        push_acc = push && (!full_m || pop);
        pop_acc  = pop && !empty_m;
        ev       = (push && full_m && !pop) || (pop && empty_m);
        @(posedge clock);
        #1;
        b_push = 1'b0; b_pop = 1'b0; b_clear = 1'b0;
        if (clr) begin
            qb.delete();
            eb_exp = 1'b0;
        end else begin
            if (pop_acc) drop = qb.pop_front();
            if (push_acc) qb.push_back(din);
            eb_exp = eb_exp | ev;
        end
        b_check(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        a_clear = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_din = 8'h00; a_ae = 3'd1; a_af = 3'd1;
        b_clear = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = 8'h00; b_ae = 5'd3; b_af = 5'd2;
        da_exp = 8'h00; ea_exp = 1'b0; ec_exp = 1'b0; eb_exp = 1'b0;

        #3;
        a_check("reset");
        b_check("reset");
        #8 reset_n = 1'b1;

        // First pass: fill DEPTH=5 with 0x11..0x55, then drain in order.
        for (int i = 1; i <= 5; i++) a_step("fill", 1'b1, 1'b0, 1'b0, 8'(8'h11 * i));
        for (int i = 0; i < 5; i++) a_step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
        // Idle after empty: data_o holds the last popped word.
        a_step("hold", 1'b0, 1'b0, 1'b0, 8'h00);

        // Second pass with pointer wrap.
        for (int i = 0; i < 4; i++) a_step("wrap_fill", 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 2; i++) a_step("wrap_pop", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) a_step("wrap_refill", 1'b1, 1'b0, 1'b0, 8'(8'h64 + i));

        // Full with simultaneous push and pop: both accepted, no error.
        a_step("full_pushpop", 1'b1, 1'b1, 1'b0, 8'h77);
        // Overflow: unlatched error pulses, latched error holds.
        a_step("overflow", 1'b1, 1'b0, 1'b0, 8'h88);
        a_step("overflow_after", 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) a_step("drain2", 1'b0, 1'b1, 1'b0, 8'h00);
        // Empty with push and pop: push wins, pop underflows.
        a_step("empty_pushpop", 1'b1, 1'b1, 1'b0, 8'h99);
        a_step("underflow_after", 1'b0, 1'b0, 1'b0, 8'h00);
        a_step("clear_a", 1'b0, 1'b0, 1'b1, 8'h00);

        // Show-ahead: first word visible without a pop.
        b_step("sa_push", 1'b1, 1'b0, 1'b0, 8'hA5);
        b_step("sa_idle", 1'b0, 1'b0, 1'b0, 8'h00);
        // Fill to 14 walking through the threshold boundaries.
        for (int i = 2; i <= 14; i++) b_step("thresh_fill", 1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
        // Show-ahead pop exposes the next entry, then drain to empty.
        for (int i = 0; i < 14; i++) b_step("sa_pop", 1'b0, 1'b1, 1'b0, 8'h00);
        // Underflow latches in this instance.
        b_step("b_underflow", 1'b0, 1'b1, 1'b0, 8'h00);
        b_step("b_underflow_hold", 1'b0, 1'b0, 1'b0, 8'h00);
        // Threshold change takes effect without a clock edge.
        b_af = 5'd20;
        #1;
        b_check("af_oversize");
        b_af = 5'd2;
        #1;
        b_check("af_restore");
        // Fill to 7 then clear while pushing.
        for (int i = 0; i < 7; i++) b_step("pre_clear", 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        b_step("clear_push", 1'b1, 1'b0, 1'b1, 8'hCC);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) b_step("burst_b", 1'b1, 1'b0, 1'b0, 8'(8'hD0 + i));
        a_step("burst_a0", 1'b1, 1'b0, 1'b0, 8'hE0);
        a_step("burst_a1", 1'b1, 1'b1, 1'b0, 8'hE1);
        a_push = 1'b1; b_push = 1'b1;
        reset_n = 1'b0;
        #2;
        qa.delete(); qb.delete();
        da_exp = 8'h00; ea_exp = 1'b0; ec_exp = 1'b0; eb_exp = 1'b0;
        a_check("async_reset");
        b_check("async_reset");
        a_push = 1'b0; b_push = 1'b0;
        #1 reset_n = 1'b1;
        a_step("post_reset", 1'b1, 1'b0, 1'b0, 8'hF1);
        a_step("post_reset_pop", 1'b0, 1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kw_fifo_flex.md
Name: KW_fifo_flex

Overview:
Second-generation single-clock FF-based FIFO that supersedes the fixed-threshold FIFO.
- Depth need not be a power of two.
- Almost-empty/almost-full thresholds are runtime inputs rather than parameters.
- Adds a fill-level output, a synchronous clear, and a selectable show-ahead (first-word-fall-through) read mode.
- Used as the general datapath buffer between streaming blocks.

Parameters:
DATA_WIDTH, 16, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
SHOW_AHEAD, 0, 0 = registered read (data one cycle after pop); 1 = head word visible on data_o whenever non-empty
ERR_MODE, 1, 0 = latched error plus internal pointer/count consistency check; 1 = latched error; 2 = unlatched error
LEVEL_WIDTH, $clog2(DEPTH+1), derived; width of level and threshold ports (not to be overridden)

Ports:
clock  input  1  clock, all state on rising edge
reset_n  input  1  reset, active low, ASYNC
clear  input  1  synchronous clear, active high
push_req  input  1  push request
pop_req  input  1  pop request
data_i  input  DATA_WIDTH  push data
data_o  output  DATA_WIDTH  pop data
ae_level  input  LEVEL_WIDTH  almost-empty threshold
af_level  input  LEVEL_WIDTH  almost-full offset from DEPTH
level  output  LEVEL_WIDTH  current occupancy, 0..DEPTH
empty  output  1  level == 0
almost_empty  output  1  level <= ae_level
half_full  output  1  level >= (DEPTH+1)/2
almost_full  output  1  level >= DEPTH - af_level; if af_level >= DEPTH, threshold is 0 and the flag is always 1
full  output  1  level == DEPTH
error  output  1  overflow/underflow indication, active high

Behaviour:
- Reset (async) values:
  - level = 0, rd_ptr = wr_ptr = 0, data_o = 0, error = 0.
  - empty = 1, almost_empty = 1, half_full = almost_full = full = 0.
- Storage is not reset.
- clear:
  - Same state as reset, applied at the next edge.
  - Overrides push/pop in that cycle; storage untouched; latched error is cleared.
- Push accepted iff push_req && (!full || pop_req).
  - Write data_i at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Pop accepted iff pop_req && !empty.
  - rd_ptr advances with the same wrap.
- Simultaneous accepted push + pop: level unchanged.
  - At full: both accepted.
  - At empty: push accepted, pop rejected (underflow).
- level: +1 on push-only, -1 on pop-only, registered.
  - All flags derive combinationally from registered level and the current threshold inputs.
  - Flags therefore update the cycle after the causing edge.
- Thresholds may change at any time; flags follow in the same cycle.
- SHOW_AHEAD=0:
  - On an accepted pop, data_o <= mem[rd_ptr] at that edge.
  - data_o otherwise holds its value, including after the FIFO empties.
- SHOW_AHEAD=1:
  - data_o = mem[rd_ptr] combinationally; valid whenever empty == 0, don't-care when empty.
  - First word visible the cycle after its push into an empty FIFO.
- Overflow = push_req && full && !pop_req.
- Underflow = pop_req && empty.
- Rejected requests change no state except error.
- error timing: registered, asserted the cycle after the offending edge.
  - ERR_MODE 1: stays high until reset/clear.
  - ERR_MODE 2: high for exactly the cycle following each offending request.
  - ERR_MODE 0: as mode 1, plus latches if level != (wr_ptr - rd_ptr) mod DEPTH, excepting full where the pointers are equal and level == DEPTH.
- Reset asserted mid-operation immediately forces reset values regardless of clock.

Test Plan:
- DEPTH=5, SHOW_AHEAD=0: push 0x11..0x55 on 5 consecutive cycles.
  - full=1 and level=5.
  - Then pop 5 cycles: data_o = 0x11,0x22,0x33,0x44,0x55, each one cycle after its pop.
  - empty=1 after the last pop; pointers wrap correctly on a second pass.
- Full FIFO with push+pop same cycle: level stays DEPTH, error stays 0, the popped word is the oldest.
- Empty FIFO with push+pop same cycle: level=1, error=1 next cycle.
  - ERR_MODE=2: error drops the following cycle.
  - ERR_MODE=1: error holds until clear.
- SHOW_AHEAD=1: push 0xA5 into empty.
  - Next cycle data_o=0xA5 with no pop.
  - Pop: data_o shows the next entry the following cycle, or empty=1.
- Thresholds with DEPTH=16, ae_level=3, af_level=2:
  - Fill to 3: almost_empty=1; at 4: almost_empty=0.
  - At 14: almost_full=1. At 8: half_full=1.
  - Change af_level to 20: almost_full=1 at level 0.
- Assert clear at level 7 with push_req=1: next cycle level=0, empty=1, error=0.
  - Async reset_n pulse mid-burst: outputs go to reset values without a clock edge.
